// File: rtl/display_shadow_regs.sv
// display_shadow_regs: frame-synchronous shadow bank for the VGA controller.
// Snoops register-file writes into a pending bank and copies pending to the
// visible bank only at frame_end, so a displayed frame never mixes game states.
// Optional feature macro: DISPLAY_HISCORE_TRACK_EN (hardware-maintained high_score).
module display_shadow_regs #(
    parameter int unsigned BASE_REG  = 16,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 we,
    input  logic [4:0]           waddr,
    input  logic [31:0]          wdata,
    input  logic                 frame_end,
    output logic [31:0]          pipe1x,
    output logic [31:0]          pipe2x,
    output logic [31:0]          pipe3x,
    output logic [31:0]          pipe4x,
    output logic [31:0]          pipe1bottomtop,
    output logic [31:0]          pipe2bottomtop,
    output logic [31:0]          pipe3bottomtop,
    output logic [31:0]          pipe4bottomtop,
    output logic [31:0]          pipe1yspace,
    output logic [31:0]          pipe2yspace,
    output logic [31:0]          pipe3yspace,
    output logic [31:0]          pipe4yspace,
    output logic [31:0]          bird_top_left,
    output logic [31:0]          current_score,
    output logic [31:0]          high_score,
    output logic                 frame_committed,
    output logic                 pending_dirty,
    output logic [CNT_WIDTH-1:0] commit_count
);

    localparam int unsigned NUM_REGS = 15;
    localparam int unsigned OFF_W    = 4;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned CUR_OFF  = 13;
    localparam int unsigned HI_OFF   = 14;
`ifdef DISPLAY_HISCORE_TRACK_EN
    // high_score is owned by hardware, so its offset is not writable
    localparam int unsigned LAST_WR_OFF = 13;
`else
    localparam int unsigned LAST_WR_OFF = 14;
`endif

    typedef enum logic {
        CLEAN = 1'b0,
        DIRTY = 1'b1
    } state_t;

    state_t                  state_q;
    state_t                  state_d;
    logic                    commit_c;
    logic                    wr_accept_c;
    logic [OFF_W-1:0]        wr_off_c;
    logic [31:0]             waddr_ext_c;
    logic [DATA_W-1:0]       pending_q [NUM_REGS];
    logic [DATA_W-1:0]       visible_q [NUM_REGS];
    logic                    frame_committed_q;
    logic [CNT_WIDTH-1:0]    commit_count_q;

    // Decode a register-file write into the bank window
    always_comb begin
        waddr_ext_c = 32'(waddr);
        wr_accept_c = we && (waddr != 5'd0)
                      && (waddr_ext_c >= BASE_REG)
                      && (waddr_ext_c <= BASE_REG + LAST_WR_OFF);
        wr_off_c    = OFF_W'(waddr_ext_c - BASE_REG);
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= CLEAN;
        else       state_q <= state_d;
    end

    // Next state and commit decision; a write racing a commit keeps the bank dirty
    always_comb begin
        state_d  = state_q;
        commit_c = 1'b0;
        case (state_q)
            CLEAN: begin
                if (wr_accept_c) state_d = DIRTY;
            end
            DIRTY: begin
                if (frame_end) begin
                    commit_c = 1'b1;
                    state_d  = wr_accept_c ? DIRTY : CLEAN;
                end
            end
            default: state_d = CLEAN;
        endcase
    end

    // Pending bank captures accepted writes, last write wins
    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q <= '{default: '0};
        end else if (wr_accept_c) begin
            pending_q[wr_off_c] <= wdata;
        end
    end

    // Visible bank, commit pulse and commit counter update together at commit
    always_ff @(posedge clk) begin
        if (reset) begin
            visible_q         <= '{default: '0};
            frame_committed_q <= 1'b0;
            commit_count_q    <= '0;
        end else begin
            frame_committed_q <= commit_c;
            if (commit_c) begin
                visible_q      <= pending_q;
`ifdef DISPLAY_HISCORE_TRACK_EN
                visible_q[HI_OFF] <= (pending_q[CUR_OFF] > visible_q[HI_OFF]) ?
                                     pending_q[CUR_OFF] : visible_q[HI_OFF];
`endif
                commit_count_q <= commit_count_q + CNT_WIDTH'(1);
            end
        end
    end

    // Output mapping of registered state
    assign pipe1x          = visible_q[0];
    assign pipe2x          = visible_q[1];
    assign pipe3x          = visible_q[2];
    assign pipe4x          = visible_q[3];
    assign pipe1bottomtop  = visible_q[4];
    assign pipe2bottomtop  = visible_q[5];
    assign pipe3bottomtop  = visible_q[6];
    assign pipe4bottomtop  = visible_q[7];
    assign pipe1yspace     = visible_q[8];
    assign pipe2yspace     = visible_q[9];
    assign pipe3yspace     = visible_q[10];
    assign pipe4yspace     = visible_q[11];
    assign bird_top_left   = visible_q[12];
    assign current_score   = visible_q[CUR_OFF];
    assign high_score      = visible_q[HI_OFF];
    assign frame_committed = frame_committed_q;
    assign pending_dirty   = (state_q == DIRTY);
    assign commit_count    = commit_count_q;

endmodule

// File: tb/tb_display_shadow_regs.sv
// Testbench for display_shadow_regs (CNT_WIDTH=2 to exercise counter wrap).
// Stimulus pushes expected commit snapshots; a monitor checks each commit pulse.
module tb_display_shadow_regs;

    localparam int unsigned CW = 2;

    logic          clk;
    logic          reset;
    logic          we;
    logic [4:0]    waddr;
    logic [31:0]   wdata;
    logic          frame_end;
    logic [31:0]   pipe1x, pipe2x, pipe3x, pipe4x;
    logic [31:0]   pipe1bottomtop, pipe2bottomtop, pipe3bottomtop, pipe4bottomtop;
    logic [31:0]   pipe1yspace, pipe2yspace, pipe3yspace, pipe4yspace;
    logic [31:0]   bird_top_left, current_score, high_score;
    logic          frame_committed;
    logic          pending_dirty;
    logic [CW-1:0] commit_count;

    display_shadow_regs #(.BASE_REG(16), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .frame_end(frame_end),
        .pipe1x(pipe1x), .pipe2x(pipe2x), .pipe3x(pipe3x), .pipe4x(pipe4x),
        .pipe1bottomtop(pipe1bottomtop), .pipe2bottomtop(pipe2bottomtop),
        .pipe3bottomtop(pipe3bottomtop), .pipe4bottomtop(pipe4bottomtop),
        .pipe1yspace(pipe1yspace), .pipe2yspace(pipe2yspace),
        .pipe3yspace(pipe3yspace), .pipe4yspace(pipe4yspace),
        .bird_top_left(bird_top_left), .current_score(current_score),
        .high_score(high_score), .frame_committed(frame_committed),
        .pending_dirty(pending_dirty), .commit_count(commit_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dut_vis [15];
    assign dut_vis[0]  = pipe1x;
    assign dut_vis[1]  = pipe2x;
    assign dut_vis[2]  = pipe3x;
    assign dut_vis[3]  = pipe4x;
    assign dut_vis[4]  = pipe1bottomtop;
    assign dut_vis[5]  = pipe2bottomtop;
    assign dut_vis[6]  = pipe3bottomtop;
    assign dut_vis[7]  = pipe4bottomtop;
    assign dut_vis[8]  = pipe1yspace;
    assign dut_vis[9]  = pipe2yspace;
    assign dut_vis[10] = pipe3yspace;
    assign dut_vis[11] = pipe4yspace;
    assign dut_vis[12] = bird_top_left;
    assign dut_vis[13] = current_score;
    assign dut_vis[14] = high_score;

    typedef struct {
        logic [31:0]   v [15];
        logic [CW-1:0] cnt;
        logic          dirty;
    } exp_t;

    exp_t        sb [$];
    int          n_cmp  = 0;
    int          n_fail = 0;

    logic [31:0]   m_pend [15];
    logic [31:0]   m_vis  [15];
    logic [CW-1:0] m_cnt;
    logic          m_dirty;

`ifdef DISPLAY_HISCORE_TRACK_EN
    localparam int LAST_ADDR = 29;
`else
    localparam int LAST_ADDR = 30;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 15; i++) begin
            m_pend[i] = '0;
            m_vis[i]  = '0;
        end
        m_cnt   = '0;
        m_dirty = 1'b0;
    endtask

    // One clock of stimulus; expected commit snapshot queued before the edge
    task automatic step(input logic w, input logic [4:0] a, input logic [31:0] d, input logic fe);
        int          ai;
        logic        acc;
        logic [31:0] hi;
        exp_t        e;
        ai  = int'(a);
        acc = w && (ai != 0) && (ai >= 16) && (ai <= LAST_ADDR);
        we = w; waddr = a; wdata = d; frame_end = fe;
        if (fe && m_dirty) begin
            hi    = m_vis[14];
            m_vis = m_pend;
`ifdef DISPLAY_HISCORE_TRACK_EN
            m_vis[14] = (m_pend[13] > hi) ? m_pend[13] : hi;
`endif
            m_cnt   = m_cnt + CW'(1);
            e.v     = m_vis;
            e.cnt   = m_cnt;
            e.dirty = acc;
            sb.push_back(e);
        end
        if (acc) m_pend[ai - 16] = d;
        m_dirty = (fe && m_dirty) ? acc : (m_dirty || acc);
        @(posedge clk); #1;
        we = 1'b0; frame_end = 1'b0;
        chk("pending_dirty", 32'(pending_dirty), 32'(m_dirty));
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 15; i++)
            chk($sformatf("%s.vis[%0d]", tag, i), dut_vis[i], m_vis[i]);
        chk({tag, ".commit_count"}, 32'(commit_count), 32'(m_cnt));
        chk({tag, ".pending_dirty"}, 32'(pending_dirty), 32'(m_dirty));
    endtask

    // Reset with a simultaneous write and frame_end to show reset priority
    task automatic do_reset();
        reset = 1'b1; we = 1'b1; waddr = 5'd16; wdata = 32'h1234; frame_end = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; we = 1'b0; frame_end = 1'b0;
        model_clear();
        chk("reset.frame_committed", 32'(frame_committed), 32'd0);
    endtask

    // Monitor: every commit pulse must match the oldest queued snapshot
    always @(negedge clk) begin
        if (!reset && frame_committed) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_commit: got frame_committed=1 expected 0 at %0t", $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                for (int i = 0; i < 15; i++) begin
                    n_cmp++;
                    if (dut_vis[i] !== e.v[i]) begin
                        n_fail++;
                        $display("FAIL commit.vis[%0d]: got %0h expected %0h", i, dut_vis[i], e.v[i]);
                    end
                end
                n_cmp++;
                if (commit_count !== e.cnt) begin
                    n_fail++;
                    $display("FAIL commit.count: got %0d expected %0d", commit_count, e.cnt);
                end
                n_cmp++;
                if (pending_dirty !== e.dirty) begin
                    n_fail++;
                    $display("FAIL commit.dirty: got %0b expected %0b", pending_dirty, e.dirty);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; we = 1'b0; waddr = '0; wdata = '0; frame_end = 1'b0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        do_reset();
        check_all("reset");

        // Idle frames in CLEAN: nothing commits
        repeat (3) begin
            step(1'b0, 5'd0, 32'd0, 1'b1);
            step(1'b0, 5'd0, 32'd0, 1'b0);
        end
        check_all("idle");

        // Basic commit
        step(1'b1, 5'd16, 32'd100, 1'b0);
        step(1'b1, 5'd28, 32'd200, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("basic.pipe1x", pipe1x, 32'd100);
        chk("basic.bird", bird_top_left, 32'd200);
        chk("basic.count", 32'(commit_count), 32'd1);
        chk("basic.fc_high", 32'(frame_committed), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b0);
        chk("basic.fc_low", 32'(frame_committed), 32'd0);

        // Write racing frame_end in DIRTY, then back-to-back frame_end
        step(1'b1, 5'd16, 32'd3, 1'b0);
        step(1'b1, 5'd16, 32'd5, 1'b1);
        chk("race.pipe1x", pipe1x, 32'd3);
        chk("race.dirty", 32'(pending_dirty), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("race2.pipe1x", pipe1x, 32'd5);
        chk("race2.count", 32'(commit_count), 32'd3);

        // Out-of-window writes are ignored
        step(1'b1, 5'd0,  32'hFFFF_FFFF, 1'b0);
        step(1'b1, 5'd15, 32'hFFFF_FFFF, 1'b0);
        step(1'b1, 5'd31, 32'hFFFF_FFFF, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("ignored.fc", 32'(frame_committed), 32'd0);
        chk("ignored.pipe1x", pipe1x, 32'd5);
        check_all("ignored");

        // Write with frame_end while CLEAN: accepted, no commit
        step(1'b1, 5'd17, 32'd9, 1'b1);
        chk("cleanrace.fc", 32'(frame_committed), 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("cleanrace.pipe2x", pipe2x, 32'd9);
        chk("wrap.count", 32'(commit_count), 32'd0);

        // Score tracking
        step(1'b1, 5'd29, 32'd7, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("score7.cur", current_score, 32'd7);
        chk("score7.count", 32'(commit_count), 32'd1);
`ifdef DISPLAY_HISCORE_TRACK_EN
        chk("score7.hi", high_score, 32'd7);
`else
        chk("score7.hi", high_score, 32'd0);
`endif
        step(1'b1, 5'd29, 32'd4, 1'b0);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("score4.cur", current_score, 32'd4);
`ifdef DISPLAY_HISCORE_TRACK_EN
        chk("score4.hi", high_score, 32'd7);
`else
        chk("score4.hi", high_score, 32'd0);
`endif
        step(1'b1, 5'd30, 32'd1, 1'b0);
`ifdef DISPLAY_HISCORE_TRACK_EN
        chk("r30.dirty", 32'(pending_dirty), 32'd0);
`else
        chk("r30.dirty", 32'(pending_dirty), 32'd1);
`endif
        step(1'b0, 5'd0, 32'd0, 1'b1);
`ifdef DISPLAY_HISCORE_TRACK_EN
        chk("r30.hi", high_score, 32'd7);
`else
        chk("r30.hi", high_score, 32'd1);
`endif

        // Rewriting the same value still dirties the bank
        step(1'b1, 5'd29, 32'd4, 1'b0);
        chk("samevalue.dirty", 32'(pending_dirty), 32'd1);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("samevalue.fc", 32'(frame_committed), 32'd1);

        // Reset discards pending writes
        step(1'b1, 5'd18, 32'hDEAD, 1'b0);
        step(1'b1, 5'd20, 32'hBEEF, 1'b0);
        do_reset();
        check_all("midreset");
        chk("midreset.pipe1x", pipe1x, 32'd0);
        step(1'b0, 5'd0, 32'd0, 1'b1);
        chk("postreset.fc", 32'(frame_committed), 32'd0);
        check_all("postreset");
        step(1'b0, 5'd0, 32'd0, 1'b0);

        repeat (2) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/display_shadow_regs.md
# display_shadow_regs

Frame-synchronous shadow register bank that sits directly upstream of the VGA controller. It snoops the processor's register-file write port and captures writes to the fifteen game-state registers: pipe positions, gap geometry, bird position and scores. It presents them to the display as a stable bank that changes only at frame boundaries, so a frame never mixes old and new game state.

## Interface
Parameters:
- BASE_REG, 16, register-file index mapped to bank offset 0; offsets 0–14 occupy BASE_REG..BASE_REG+14; must satisfy 1 ≤ BASE_REG ≤ 17
- CNT_WIDTH, 16, width of commit_count

Ports:
- clk  input  1  100 MHz system clock; the only clock
- reset  input  1  synchronous, active-high reset
- we  input  1  register-file write enable
- waddr  input  5  register-file write index
- wdata  input  32  register-file write data
- frame_end  input  1  one-cycle pulse in clk domain marking the blanking gap between frames
- pipe1x, pipe2x, pipe3x, pipe4x  output  32 each  visible bank, offsets 0–3
- pipe1bottomtop..pipe4bottomtop  output  32 each  offsets 4–7
- pipe1yspace..pipe4yspace  output  32 each  offsets 8–11
- bird_top_left  output  32  offset 12
- current_score  output  32  offset 13
- high_score  output  32  offset 14
- frame_committed  output  1  one-cycle pulse: visible bank updated this cycle
- pending_dirty  output  1  pending bank differs from visible by at least one accepted write
- commit_count  output  CNT_WIDTH  number of commits since reset, wraps

## Operation
- Two banks of 15×32 bits: pending and visible. All outputs are registered.
- Write acceptance: a write is accepted when we=1, waddr≠0, and BASE_REG ≤ waddr ≤ BASE_REG+14. It stores wdata to pending[waddr−BASE_REG] and sets dirty. All other writes are ignored.
- Multiple writes to one offset before a commit: the last value wins.
- State machine has two states:
  - CLEAN: dirty=0. frame_end does nothing.
  - DIRTY: dirty=1. frame_end copies all of pending to visible, pulses frame_committed, increments commit_count, and returns to CLEAN.
- A write in the same cycle as frame_end in DIRTY:
  - The commit copies pending as it was before that write.
  - The write lands in pending.
  - State stays DIRTY, so the write appears at the next frame_end.
- A write in the same cycle as frame_end in CLEAN: the write is accepted, the state goes to DIRTY, and no commit occurs.
- A write whose data equals the stored value still sets dirty. There is no compare.
- commit_count wraps from 2^CNT_WIDTH−1 to 0.
- Reset:
  - Clears both banks, so all outputs are 0. The all-zero state is the splash/idle screen for the display.
  - frame_committed=0, pending_dirty=0, commit_count=0, state CLEAN.
  - Reset takes priority over a simultaneous write or frame_end.
  - A reset asserted mid-frame discards pending writes.

## Timing
- Accepted write at cycle N: pending updated and pending_dirty=1 at N+1.
- frame_end at cycle F in DIRTY: visible outputs, frame_committed=1, and the incremented commit_count all appear at F+1. frame_committed is low at F+2. pending_dirty=0 at F+1 unless a same-cycle write occurred.
- Write-to-display latency is from N+1 to the end of the next frame. No combinational path from inputs to outputs.
- frame_end pulses closer together than 2 cycles are legal. Each is evaluated independently against the current state.

## Configuration
- DISPLAY_HISCORE_TRACK_EN defined:
  - high_score is maintained in hardware.
  - Writes to offset 14 are ignored and do not set dirty.
  - On each commit, visible high_score becomes max(old high_score, newly committed current_score), compared unsigned and applied in the same F+1 cycle.
  - Reset clears high_score to 0.
- Not defined: high_score is an ordinary shadowed register like the other offsets.

## Test plan
- Reset, then idle for 3 frame_end pulses → all outputs 0, frame_committed never asserted, commit_count=0.
- Write r16=100 and r28=200, then frame_end → pipe1x=100 and bird_top_left=200 at F+1; frame_committed high exactly 1 cycle; commit_count=1; pending_dirty=0.
- Write r16=5 in the same cycle as frame_end with r16 previously pending 3 → pipe1x=3 at F+1 with pending_dirty=1; pipe1x=5 after the next frame_end.
- Writes to r0, r15 and r31 with wdata=32'hFFFFFFFF, then frame_end → no output change, no commit, pending_dirty stays 0.
- With DISPLAY_HISCORE_TRACK_EN defined:
  - Commit current_score=7 → high_score=7.
  - Commit current_score=4 → high_score stays 7.
  - Write r30=1 → ignored.
- Set CNT_WIDTH=2 and perform 5 dirty commits → commit_count sequence 1,2,3,0,1; reset mid-sequence with pending writes → all outputs 0 next cycle and the pending data is never displayed.
